fft_frame_collector: RTL and testbench
======================================

// Module: fft_frame_collector
// PURPOSE
//  Streaming-to-frame front end of the FFT datapath. Accepts one W-bit complex sample
//  per cycle on a valid/ready stream, assembles 2**N consecutive samples into a frame,
//  and presents the whole frame in parallel to bit_reverse_mapper (natural order in[i]).
//  Ping-pong double buffering lets input continue while the downstream holds a frame.
// PARAMETERS
//  N       3   log2 of frame size; SIZE = 2**N samples per frame
//  W       32  sample width ({re[15:0], im[15:0]}); opaque to this block
// PORTS
//  clk          in   1         single clock, all logic rising-edge
//  rst          in   1         asynchronous, active-high reset
//  s_valid      in   1         input sample valid
//  s_ready      out  1         block can accept a sample this cycle
//  s_data       in   W         input sample
//  s_last       in   1         producer marks final sample of its frame
//  frame_valid  out  1         frame_data holds a complete frame
//  frame_ready  in   1         downstream consumes frame this cycle
//  frame_data   out  SIZE*W    packed [SIZE-1:0][W-1:0]; element i = i-th sample received
//  frame_err    out  1         one-cycle pulse: s_last position mismatch, frame dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): both banks empty, wr_bank=0, rd_bank=0,
//    wr_idx=0; outputs s_ready=0 while rst high, 1 first cycle after; frame_valid=0,
//    frame_err=0, frame_data=0.
//  - Accept = s_valid & s_ready. On accept: bank[wr_bank][wr_idx] <= s_data,
//    wr_idx increments (N bits, wraps SIZE-1 -> 0).
//  - s_ready = ~full[wr_bank]. Backpressure only when both banks are full.
//  - Frame completion: accept with wr_idx==SIZE-1 and s_last=1 -> full[wr_bank]<=1,
//    wr_bank toggles, wr_idx<=0.
//  - Framing error: accept with (wr_idx==SIZE-1) != s_last -> frame_err pulses next
//    cycle, current bank's contents discarded (full stays 0), wr_idx<=0, wr_bank
//    unchanged. The offending sample is not kept.
//  - Output: frame_valid = full[rd_bank]; frame_data = bank[rd_bank] (registered
//    storage, no extra output stage). frame_valid rises the cycle after the
//    completing accept (latency 1 clk from last sample to frame_valid).
//  - Handshake: frame_data stable while frame_valid & ~frame_ready. On
//    frame_valid & frame_ready: full[rd_bank]<=0, rd_bank toggles.
//  - Simultaneous: frame consume and completion of the other bank in the same cycle
//    are both honoured; if both banks were full, s_ready rises the cycle after the
//    consume (no combinational ready path from frame_ready to s_ready).
//  - Two banks full: frame_valid stays 1 back-to-back; second frame presented the
//    cycle after first is consumed.
//  - Reset mid-frame or with frames pending: all partial/complete frames discarded.
//  - s_data is never inspected; no arithmetic on samples.
// STRUCTURE
//  - fft_pkg: FFT_LOG2N, FFT_SIZE, SAMPLE_W localparams; typedef logic [SAMPLE_W-1:0]
//    sample_t; typedef sample_t [FFT_SIZE-1:0] frame_t (shared with bit_reverse_mapper
//    and butterfly stages).
//  - Sub-module fft_frame_bank: SIZE-entry register bank with write-enable, write
//    index, full flag set/clear; instantiated twice. Top holds wr_bank/rd_bank/wr_idx
//    control and the framing check.
// TESTING
//  1 Reset then stream 0..7 with s_last on 7, frame_ready=1 -> frame_valid one cycle
//    after sample 7, frame_data[i]=i, pulse 1 cycle, frame_err never.
//  2 frame_ready=0, stream 16 samples (0..15) -> s_ready low after 16th accept,
//    frame_data[i]=i held; pulse frame_ready -> frame_data[i]=8+i, s_ready back high.
//  3 s_last on 5th sample of a frame -> frame_err pulse, no frame_valid; next clean
//    8 samples 100..107 -> frame_data[i]=100+i.
//  4 Sample 7 with s_last=0 -> frame_err, frame dropped; following frame accepted.
//  5 Assert rst after 4 samples with one full frame pending -> frame_valid=0
//    immediately, new frame 20..27 delivered correctly after release.
//  6 Random s_valid/frame_ready gaps, 50 frames -> scoreboard match, no loss/dup.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg.sv - shared FFT datapath sizes and sample/frame types
// Purpose: frame geometry and sample/frame types shared by the frame collector,
//          bit_reverse_mapper and the butterfly stages.
// Contents: FFT_LOG2N, FFT_SIZE, SAMPLE_W, sample_t, frame_t.
package fft_pkg;
    localparam int FFT_LOG2N = 3;
    localparam int FFT_SIZE  = 2 ** FFT_LOG2N;
    localparam int SAMPLE_W  = 32;

    typedef logic [SAMPLE_W-1:0]    sample_t;
    typedef sample_t [FFT_SIZE-1:0] frame_t;
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank.sv - one SIZE-entry sample bank with a full flag
// Purpose: holds one frame of samples for the ping-pong collector.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears samples and flag)
//   wr_en      write wr_data into entry wr_idx
//   wr_idx     entry index (N bits)
//   wr_data    sample to store
//   set_full   mark bank as holding a complete frame
//   clr_full   release bank after the frame is consumed
//   full       bank holds a complete frame
//   data       all SIZE entries, entry i = i-th sample written
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N = FFT_LOG2N,
    parameter int W = SAMPLE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [N-1:0]              wr_idx,
    input  logic [W-1:0]              wr_data,
    input  logic                      set_full,
    input  logic                      clr_full,
    output logic                      full,
    output logic [2**N-1:0][W-1:0]    data
);
    logic [2**N-1:0][W-1:0] mem_d, mem_q;
    logic                   full_d, full_q;

    always_comb begin
        mem_d  = mem_q;
        full_d = full_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
        if (clr_full) begin
            full_d = 1'b0;
        end
        if (set_full) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;
    assign data = mem_q;
endmodule

// File: rtl/fft_frame_collector.sv
// fft_frame_collector.sv - stream-to-frame ping-pong collector for the FFT
// Purpose: assembles 2**N consecutive samples into a frame and presents it in
//          parallel, natural order, while the other bank keeps filling.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last  input sample stream, s_last marks frame end
//   frame_valid/frame_ready        frame handshake towards bit_reverse_mapper
//   frame_data                     packed frame, element i = i-th sample received
//   frame_err                      one-cycle pulse when s_last position is wrong
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int N = FFT_LOG2N,
    parameter int W = SAMPLE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [W-1:0]              s_data,
    input  logic                      s_last,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [2**N-1:0][W-1:0]    frame_data,
    output logic                      frame_err
);
    logic                   wr_bank_d, wr_bank_q;
    logic                   rd_bank_d, rd_bank_q;
    logic [N-1:0]           wr_idx_d, wr_idx_q;
    logic                   err_d, err_q;
    // Held low through reset so s_ready only rises after reset release.
    logic                   ready_en_d, ready_en_q;

    logic                   full0, full1;
    logic [2**N-1:0][W-1:0] data0, data1;
    logic                   wr_full;
    logic                   accept, last_pos, mismatch, complete, consume;
    logic                   wr_en;

    assign wr_full  = wr_bank_q ? full1 : full0;
    assign s_ready  = ready_en_q & ~wr_full;
    assign accept   = s_valid & s_ready;
    assign last_pos = (wr_idx_q == {N{1'b1}});
    assign mismatch = last_pos != s_last;
    assign complete = accept & last_pos & s_last;
    assign consume  = frame_valid & frame_ready;
    // The offending sample of a framing error is never stored.
    assign wr_en    = accept & ~mismatch;

    assign frame_valid = rd_bank_q ? full1 : full0;
    assign frame_data  = rd_bank_q ? data1 : data0;
    assign frame_err   = err_q;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_idx_d   = wr_idx_q;
        err_d      = accept & mismatch;
        ready_en_d = 1'b1;
        if (accept) begin
            if (mismatch || complete) begin
                wr_idx_d = '0;
            end else begin
                wr_idx_d = wr_idx_q + N'(1);
            end
        end
        if (complete) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (consume) begin
            rd_bank_d = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            err_q      <= err_d;
            ready_en_q <= ready_en_d;
        end
    end

    // A partial frame in a bank is discarded simply by rewinding wr_idx; the
    // completing bank is never the one being consumed, so set/clear never collide.
    fft_frame_bank #(.N(N), .W(W)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en & ~wr_bank_q),
        .wr_idx   (wr_idx_q),
        .wr_data  (s_data),
        .set_full (complete & ~wr_bank_q),
        .clr_full (consume & ~rd_bank_q),
        .full     (full0),
        .data     (data0)
    );

    fft_frame_bank #(.N(N), .W(W)) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en & wr_bank_q),
        .wr_idx   (wr_idx_q),
        .wr_data  (s_data),
        .set_full (complete & wr_bank_q),
        .clr_full (consume & rd_bank_q),
        .full     (full1),
        .data     (data1)
    );
endmodule

// File: tb/tb_fft_frame_collector.sv
// tb/tb_fft_frame_collector.sv - self-checking bench for fft_frame_collector
module tb_fft_frame_collector;
    import fft_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    s_valid = 1'b0;
    logic    s_ready;
    sample_t s_data = '0;
    logic    s_last = 1'b0;
    logic    frame_valid;
    logic    frame_ready = 1'b0;
    frame_t  frame_data;
    logic    frame_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: list of complete frames awaiting delivery, plus the
    // frame currently being assembled.
    frame_t  pend_q[$];
    sample_t part_q[$];
    bit      out_of_reset = 0;
    bit      err_exp = 0;
    int      frames_out = 0;

    always #5 clk = ~clk;

    fft_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_err   (frame_err)
    );

    task automatic check(input string tag, input logic [FFT_SIZE*SAMPLE_W-1:0] obs,
                         input logic [FFT_SIZE*SAMPLE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("s_ready", s_ready, out_of_reset && pend_q.size() < 2);
        check("frame_valid", frame_valid, pend_q.size() > 0);
        check("frame_err", frame_err, err_exp);
        if (pend_q.size() > 0) begin
            check("frame_data", frame_data, pend_q[0]);
        end
    endtask

    // Called at a falling edge: check, drive, advance the model, move to the next falling edge.
    task automatic step(input logic v, input sample_t d, input logic l, input logic fr);
        bit rdy;
        bit acc;
        bit cons;
        frame_t f;
        check_outputs();
        s_valid     = v;
        s_data      = d;
        s_last      = l;
        frame_ready = fr;
        rdy  = out_of_reset && pend_q.size() < 2;
        acc  = v && rdy;
        cons = fr && pend_q.size() > 0;
        err_exp = 0;
        if (cons) begin
            void'(pend_q.pop_front());
            frames_out++;
        end
        if (acc) begin
            if ((part_q.size() == FFT_SIZE - 1) != l) begin
                err_exp = 1;
                part_q.delete();
            end else begin
                part_q.push_back(d);
                if (part_q.size() == FFT_SIZE) begin
                    for (int i = 0; i < FFT_SIZE; i++) f[i] = part_q[i];
                    pend_q.push_back(f);
                    part_q.delete();
                end
            end
        end
        out_of_reset = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input int base, input logic fr);
        for (int i = 0; i < FFT_SIZE; i++) begin
            step(1'b1, sample_t'(base + i), i == FFT_SIZE - 1, fr);
        end
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, fr);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_frame_data", frame_data, '0);
        pend_q.delete();
        part_q.delete();
        out_of_reset = 0;
        err_exp = 0;
        s_valid = 1'b0;
        frame_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        int fidx;
        @(negedge clk);
        apply_reset();

        // 1: single frame, downstream always ready
        send_frame(0, 1'b1);
        idle(3, 1'b1);

        // 2: two frames with downstream stalled, then release one at a time
        send_frame(0, 1'b0);
        send_frame(8, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // 3: early s_last on 5th sample, then a clean frame
        for (int i = 0; i < 5; i++) step(1'b1, sample_t'(50 + i), i == 4, 1'b1);
        idle(2, 1'b1);
        send_frame(100, 1'b1);
        idle(2, 1'b1);

        // 4: missing s_last on sample 7, then a clean frame
        for (int i = 0; i < FFT_SIZE; i++) step(1'b1, sample_t'(60 + i), 1'b0, 1'b1);
        idle(1, 1'b1);
        send_frame(200, 1'b1);
        idle(2, 1'b1);

        // 5: reset with a frame pending and a partial frame in progress
        send_frame(70, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, sample_t'(80 + i), 1'b0, 1'b0);
        apply_reset();
        send_frame(20, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // 6: random gaps and backpressure, occasional framing errors
        frames_out = 0;
        cyc = 0;
        while (frames_out < 50 && cyc < 20000) begin
            logic v, l, fr;
            v  = ($urandom_range(0, 3) != 0);
            fr = ($urandom_range(0, 2) != 0);
            l  = (part_q.size() == FFT_SIZE - 1);
            if ($urandom_range(0, 59) == 0) l = ~l;
            step(v, sample_t'($urandom), l, fr);
            cyc++;
        end
        check("random_frames_delivered", 32'(frames_out), 32'd50);
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
